// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller front end:
// controller state encodings, scheduler mode encodings, timebase and
// the car-count saturation helper.
package traffic_pkg;

    localparam int CPS = 2;

    localparam logic [3:0] ST_BLINK  = 4'd0;
    localparam logic [3:0] ST_NS_PED = 4'd1;
    localparam logic [3:0] ST_NS_G   = 4'd2;
    localparam logic [3:0] ST_NS_Y   = 4'd3;
    localparam logic [3:0] ST_NS_R   = 4'd4;
    localparam logic [3:0] ST_EW_PED = 4'd5;
    localparam logic [3:0] ST_EW_G   = 4'd6;
    localparam logic [3:0] ST_EW_Y   = 4'd7;
    localparam logic [3:0] ST_EW_R   = 4'd8;

    typedef enum logic [1:0] {
        MODE_INIT    = 2'd0,
        MODE_RUN     = 2'd1,
        MODE_PREEMPT = 2'd2,
        MODE_FAULT   = 2'd3
    } mode_e;

    // Clamp a raw sensor count to the controller's count register range.
    function automatic logic [7:0] sat_count(input logic [7:0] raw, input logic [7:0] ceil);
        return (raw > ceil) ? ceil : raw;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// Two-requester (NS/EW) round-robin bus-priority arbiter with a hold
// timer. A grant lasts at most BUS_HOLD_MAX cycles; on timeout the grant
// drops for one cycle and priority moves to the other direction.
module bus_rr_arbiter
#(
    parameter int BUS_HOLD_MAX = 30
)
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_req_ns,
    input  logic i_req_ew,
    output logic o_gnt_ns,
    output logic o_gnt_ew
);

    localparam int TW = $clog2(BUS_HOLD_MAX);
    localparam logic [TW-1:0] HOLD_LAST = TW'(BUS_HOLD_MAX - 1);

    logic          gnt_ns_q, gnt_ns_d;
    logic          gnt_ew_q, gnt_ew_d;
    logic          ptr_ew_q, ptr_ew_d;
    logic [TW-1:0] timer_q,  timer_d;
    logic          holder_req;

    // Arbitration: hold, timeout-release, or grant from idle.
    always_comb begin
        gnt_ns_d   = gnt_ns_q;
        gnt_ew_d   = gnt_ew_q;
        ptr_ew_d   = ptr_ew_q;
        timer_d    = timer_q;
        holder_req = gnt_ns_q ? i_req_ns : i_req_ew;
        if (!i_en) begin
            gnt_ns_d = 1'b0;
            gnt_ew_d = 1'b0;
            timer_d  = '0;
        end else if (gnt_ns_q || gnt_ew_q) begin
            if (!holder_req) begin
                gnt_ns_d = 1'b0;
                gnt_ew_d = 1'b0;
                timer_d  = '0;
            end else if (timer_q == HOLD_LAST) begin
                // Idle cycle after timeout keeps the two grants from touching.
                gnt_ns_d = 1'b0;
                gnt_ew_d = 1'b0;
                timer_d  = '0;
                ptr_ew_d = gnt_ns_q;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            timer_d = '0;
            if (i_req_ns && i_req_ew) begin
                gnt_ns_d = !ptr_ew_q;
                gnt_ew_d = ptr_ew_q;
                ptr_ew_d = !ptr_ew_q;
            end else begin
                gnt_ns_d = i_req_ns;
                gnt_ew_d = i_req_ew;
            end
        end
    end

    // Grant, pointer and hold-timer registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gnt_ns_q <= 1'b0;
            gnt_ew_q <= 1'b0;
            ptr_ew_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            gnt_ns_q <= gnt_ns_d;
            gnt_ew_q <= gnt_ew_d;
            ptr_ew_q <= ptr_ew_d;
            timer_q  <= timer_d;
        end
    end

    assign o_gnt_ns = gnt_ns_q;
    assign o_gnt_ew = gnt_ew_q;

endmodule

// File: rtl/traffic_request_sched.sv
// Front-end scheduler for the intersection controller: pedestrian
// latches, bus-priority arbitration, periodic car-count loads and
// emergency preemption. Optional watchdog: TRAFFIC_SCHED_WDOG_EN.
//
//  mode     | meaning
//  INIT     | one cycle after reset, controller disabled
//  RUN      | normal operation, loads / grants / ped latches active
//  PREEMPT  | emergency, controller forced to blink, waits for quiet i_emerg
//  FAULT    | i_state stuck too long, sticky until reset (watchdog only)
module traffic_request_sched
    import traffic_pkg::*;
#(
    parameter int LOAD_PERIOD  = 10 * CPS,
    parameter int BUS_HOLD_MAX = 15 * CPS,
    parameter int PREEMPT_HOLD = 10 * CPS,
    parameter int CAR_MAX      = 63
)
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_ped_ns,
    input  logic       i_btn_ped_ew,
    input  logic       i_bus_req_ns,
    input  logic       i_bus_req_ew,
    input  logic       i_emerg,
    input  logic [7:0] i_sens_ns,
    input  logic [7:0] i_sens_ew,
    input  logic [3:0] i_state,
    output logic       o_enable,
    output logic       o_load,
    output logic [7:0] o_cars_ns,
    output logic [7:0] o_cars_ew,
    output logic       o_ped_ns,
    output logic       o_ped_ew,
    output logic       o_bus_ns,
    output logic       o_bus_ew,
    output logic [1:0] o_mode,
    output logic       o_fault
);

    localparam int LW = $clog2(LOAD_PERIOD);
    localparam int HW = $clog2(PREEMPT_HOLD);
    localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_PERIOD - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(PREEMPT_HOLD - 1);
    localparam logic [7:0]    CAR_CEIL  = 8'(CAR_MAX);

    mode_e         mode_q, mode_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [LW-1:0] load_cnt_q, load_cnt_d;
    logic          enable_q, enable_d;
    logic          load_q, load_d;
    logic [7:0]    cars_ns_q, cars_ns_d;
    logic [7:0]    cars_ew_q, cars_ew_d;
    logic          ped_ns_q, ped_ns_d;
    logic          ped_ew_q, ped_ew_d;
    logic          btn_ns_prev_q, btn_ew_prev_q;
    logic          wdog_trip;
    logic          run_next;

`ifdef TRAFFIC_SCHED_WDOG_EN
    localparam int WDOG_LIMIT = 30 * CPS;
    localparam int WW = $clog2(WDOG_LIMIT + 1);
    logic [WW-1:0] wdog_q, wdog_d;
    logic [3:0]    st_prev_q;
    logic          fault_q;

    // Watchdog: count RUN cycles with unchanged controller state.
    always_comb begin
        wdog_d    = '0;
        wdog_trip = 1'b0;
        if (mode_q == MODE_RUN && i_state == st_prev_q) begin
            wdog_trip = (wdog_q == WW'(WDOG_LIMIT));
            wdog_d    = wdog_trip ? wdog_q : wdog_q + WW'(1);
        end
    end

    // Watchdog counter, state history and sticky fault flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wdog_q    <= '0;
            st_prev_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            st_prev_q <= i_state;
            fault_q   <= (mode_d == MODE_FAULT);
        end
    end

    assign o_fault = fault_q;
`else
    assign wdog_trip = 1'b0;
    assign o_fault   = 1'b0;
`endif

    // Mode state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q <= MODE_INIT;
            hold_q <= '0;
        end else begin
            mode_q <= mode_d;
            hold_q <= hold_d;
        end
    end

    // Next mode and preemption quiet-time counter.
    always_comb begin
        mode_d = mode_q;
        hold_d = hold_q;
        case (mode_q)
            MODE_INIT: mode_d = MODE_RUN;
            MODE_RUN: begin
                if (i_emerg) begin
                    mode_d = MODE_PREEMPT;
                    hold_d = '0;
                end else if (wdog_trip) begin
                    mode_d = MODE_FAULT;
                end
            end
            MODE_PREEMPT: begin
                if (i_emerg) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    mode_d = MODE_RUN;
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            MODE_FAULT: mode_d = MODE_FAULT;
            default:    mode_d = MODE_INIT;
        endcase
    end

    // Registered-output next values: enable, loads, snapshots, ped latches.
    always_comb begin
        run_next   = (mode_d == MODE_RUN);
        enable_d   = run_next;
        load_d     = run_next && ((mode_q != MODE_RUN) || (load_cnt_q == LOAD_LAST));
        load_cnt_d = (run_next && !load_d) ? load_cnt_q + LW'(1) : '0;
        cars_ns_d  = load_d ? sat_count(i_sens_ns, CAR_CEIL) : cars_ns_q;
        cars_ew_d  = load_d ? sat_count(i_sens_ew, CAR_CEIL) : cars_ew_q;
        ped_ns_d   = ped_ns_q;
        ped_ew_d   = ped_ew_q;
        // Clear takes precedence over a press in the same cycle.
        if (!run_next || i_state == ST_NS_PED) begin
            ped_ns_d = 1'b0;
        end else if (mode_q == MODE_RUN && i_btn_ped_ns && !btn_ns_prev_q) begin
            ped_ns_d = 1'b1;
        end
        if (!run_next || i_state == ST_EW_PED) begin
            ped_ew_d = 1'b0;
        end else if (mode_q == MODE_RUN && i_btn_ped_ew && !btn_ew_prev_q) begin
            ped_ew_d = 1'b1;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            enable_q      <= 1'b0;
            load_q        <= 1'b0;
            load_cnt_q    <= '0;
            cars_ns_q     <= '0;
            cars_ew_q     <= '0;
            ped_ns_q      <= 1'b0;
            ped_ew_q      <= 1'b0;
            btn_ns_prev_q <= 1'b0;
            btn_ew_prev_q <= 1'b0;
        end else begin
            enable_q      <= enable_d;
            load_q        <= load_d;
            load_cnt_q    <= load_cnt_d;
            cars_ns_q     <= cars_ns_d;
            cars_ew_q     <= cars_ew_d;
            ped_ns_q      <= ped_ns_d;
            ped_ew_q      <= ped_ew_d;
            btn_ns_prev_q <= i_btn_ped_ns;
            btn_ew_prev_q <= i_btn_ped_ew;
        end
    end

    bus_rr_arbiter #(
        .BUS_HOLD_MAX (BUS_HOLD_MAX)
    ) u_bus_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (run_next),
        .i_req_ns (i_bus_req_ns),
        .i_req_ew (i_bus_req_ew),
        .o_gnt_ns (o_bus_ns),
        .o_gnt_ew (o_bus_ew)
    );

    assign o_enable  = enable_q;
    assign o_load    = load_q;
    assign o_cars_ns = cars_ns_q;
    assign o_cars_ew = cars_ew_q;
    assign o_ped_ns  = ped_ns_q;
    assign o_ped_ew  = ped_ew_q;
    assign o_mode    = mode_q;

endmodule
